// File: rtl/arcade_pause_dim.sv
// Pause/dim controller between the core CPU and the video path. It merges the
// user toggle, the external requests and OSD-open into pause_cpu, and fades RGB in steps while paused.
module arcade_pause_dim #(
   parameter int RW          = 3,
   parameter int GW          = 3,
   parameter int BW          = 2,
   parameter int NREQ        = 2,
   parameter int TICK_CYCLES = 24000000,
   parameter int DIM_SECS    = 10,
   parameter int DIM_MAX     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  user_button,
   input  logic [NREQ-1:0]       pause_request,
   input  logic                  osd_active,
   input  logic [1:0]            options,
   input  logic [RW+GW+BW-1:0]   rgb_in,
   output logic                  pause_cpu,
   output logic                  dim_active,
   output logic [RW+GW+BW-1:0]   rgb_out
);

   localparam int PXW = RW + GW + BW;
   localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int SW  = (DIM_SECS > 0) ? $clog2(DIM_SECS + 1) : 1;
   localparam int LW  = (DIM_MAX > 0) ? $clog2(DIM_MAX + 1) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [SW-1:0] SEC_SAT    = SW'(DIM_SECS);
   localparam logic [LW-1:0] LEVEL_SAT  = LW'(DIM_MAX);

   logic            btn_prev_q, btn_prev_d;
   logic            toggle_q,   toggle_d;
   logic            pause_q,    pause_d;
   logic            dim_q,      dim_d;
   logic [PW-1:0]   presc_q,    presc_d;
   logic [SW-1:0]   sec_q,      sec_d;
   logic [LW-1:0]   level_q,    level_d;
   logic [PXW-1:0]  rgb_q,      rgb_d;
   logic            eligible_s;
   logic            tick_s;
   logic [RW-1:0]   r_s;
   logic [GW-1:0]   g_s;
   logic [BW-1:0]   b_s;

   // Next-state logic for pause merge, fade timer and per-channel shift
   always_comb begin
      btn_prev_d = user_button;
      toggle_d   = toggle_q;
      presc_d    = presc_q;
      sec_d      = sec_q;
      level_d    = level_q;
      tick_s     = 1'b0;

      if (user_button && !btn_prev_q) begin
         toggle_d = ~toggle_q;
      end else begin
         toggle_d = toggle_q;
      end

      pause_d    = toggle_d | (|pause_request) | (options[0] & osd_active);
      // A pause held only by external requests never dims the picture.
      eligible_s = pause_q & options[1] & (toggle_q | (options[0] & osd_active));

      if (eligible_s) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_s  = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
         if (tick_s && (sec_q != SEC_SAT)) begin
            sec_d = sec_q + 1'b1;
         end else begin
            sec_d = sec_q;
         end
         if (tick_s && (sec_q == SEC_SAT) && (level_q != LEVEL_SAT)) begin
            level_d = level_q + 1'b1;
         end else begin
            level_d = level_q;
         end
      end else begin
         presc_d = '0;
         sec_d   = '0;
         level_d = '0;
      end

      dim_d = (level_q != '0);
      // Each field is shifted on its own so no bits cross channel boundaries.
      r_s   = rgb_in[PXW-1 -: RW] >> level_q;
      g_s   = rgb_in[BW +: GW] >> level_q;
      b_s   = rgb_in[BW-1:0] >> level_q;
      rgb_d = {r_s, g_s, b_s};
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev_q <= 1'b0;
         toggle_q   <= 1'b0;
         pause_q    <= 1'b0;
         dim_q      <= 1'b0;
         presc_q    <= '0;
         sec_q      <= '0;
         level_q    <= '0;
         rgb_q      <= '0;
      end else begin
         btn_prev_q <= btn_prev_d;
         toggle_q   <= toggle_d;
         pause_q    <= pause_d;
         dim_q      <= dim_d;
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         level_q    <= level_d;
         rgb_q      <= rgb_d;
      end
   end

   assign pause_cpu  = pause_q;
   assign dim_active = dim_q;
   assign rgb_out    = rgb_q;

endmodule
